// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: latches two operands and an op, then walks them LSB first
// through a 1-bit AND/OR/full-add slice, collecting the result in a shift register.
module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [1:0]       opreg;

  logic [WIDTH-1:0] ashift;
  logic [WIDTH-1:0] bshift;
  logic             abit;
  logic             bbit;
  logic             s;
  logic             cnext;
  logic             arith;
  logic             lastbit;
  logic [WIDTH-1:0] shnext;

  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);
  assign arith   = opreg[1];
  assign lastbit = (cnt == CNT_W'(WIDTH - 1));

  // Shifting instead of indexing keeps the select width-agnostic for any CNT_W.
  assign ashift = areg >> cnt;
  assign bshift = breg >> cnt;
  assign abit   = ashift[0];
  assign bbit   = (opreg == OP_SUB) ? ~bshift[0] : bshift[0];

  always_comb begin
    s     = 1'b0;
    cnext = carry;
    case (opreg)
      OP_AND: s = abit & bbit;
      OP_OR:  s = abit | bbit;
      OP_ADD, OP_SUB: begin
        s     = abit ^ bbit ^ carry;
        cnext = (abit & bbit) | (abit & carry) | (bbit & carry);
      end
      default: s = 1'b0;
    endcase
  end

  assign shnext = {s, shreg[WIDTH-1:1]};

  // Result flags are loaded on the same edge that shifts in the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      shreg     <= '0;
      areg      <= '0;
      breg      <= '0;
      opreg     <= OP_AND;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            areg  <= a;
            breg  <= b;
            opreg <= op;
            cnt   <= '0;
            carry <= (op == OP_SUB);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= shnext;
          cnt   <= cnt + CNT_W'(1);
          if (arith) carry <= cnext;
          if (lastbit) begin
            state     <= DONE;
            result    <= shnext;
            zero      <= (shnext == '0);
            carry_out <= arith ? cnext : 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed vector table plus hand-written
// sequences for held start and mid-operation reset.
module tb_alu_serial_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;

  int errors;
  int checks;

  alu_serial_ctrl #(.WIDTH(8), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .op(op),
    .busy(busy),
    .done(done),
    .result(result),
    .carry_out(carry_out),
    .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] er;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation, verify the old result is held during SHIFT, then wait for done.
  task automatic applyStimulus(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                               input logic [7:0] holdExp, output int busyCycles, output bit gotDone);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = va;
    b = vb;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    op = 2'($urandom);
    checkOutput("hold_result", 32'(result), 32'(holdExp));
    busyCycles = 0;
    gotDone = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      if (done) gotDone = 1'b1;
      else begin
        if (busy) busyCycles++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int  bc;
    bit  gd;
    logic [7:0] prevRes;
    int  doneCount;
    int  doneCyc[2];
    logic [7:0] doneRes[2];
    int  sawDone;

    errors = 0;
    checks = 0;

    vecs[0] = '{"add_7f_01", 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
    vecs[1] = '{"add_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{"sub_05_05", 2'b11, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{"sub_03_05", 2'b11, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{"or_a5_5a",  2'b01, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{"and_a5_5a", 2'b00, 8'hA5, 8'h5A, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{"sub_80_01", 2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0};
    vecs[7] = '{"and_ff_3c", 2'b00, 8'hFF, 8'h3C, 8'h3C, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_carry", 32'(carry_out), 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;

    prevRes = 8'h00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, prevRes, bc, gd);
      checkOutput({vecs[i].name, "_done"}, 32'(gd), 32'd1);
      checkOutput({vecs[i].name, "_busycyc"}, 32'(bc), 32'd8);
      checkOutput({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].er));
      checkOutput({vecs[i].name, "_carry"}, 32'(carry_out), 32'(vecs[i].ec));
      checkOutput({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].ez));
      @(negedge clk);
      checkOutput({vecs[i].name, "_pulse"}, 32'(done), 32'd0);
      prevRes = vecs[i].er;
    end

    // start held for 20 cycles with changing operands: only IDLE-cycle operands count
    doneCount = 0;
    doneCyc[0] = 0;
    doneCyc[1] = 0;
    doneRes[0] = '0;
    doneRes[1] = '0;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (done) begin
        if (doneCount < 2) begin
          doneCyc[doneCount] = cyc;
          doneRes[doneCount] = result;
        end
        doneCount++;
      end
      if (cyc < 20) begin
        start = 1'b1;
        op = 2'b10;
        a = 8'(8'h10 + cyc);
        b = 8'(8'h01 + cyc);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("held_start_count", 32'(doneCount), 32'd2);
    checkOutput("held_start_gap", 32'(doneCyc[1] - doneCyc[0]), 32'd10);
    checkOutput("held_start_res0", 32'(doneRes[0]), 32'h11);
    checkOutput("held_start_res1", 32'(doneRes[1]), 32'h25);

    // Reset in the middle of SHIFT abandons the operation
    @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    a = 8'hFF;
    b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_result", 32'(result), 32'd0);
    checkOutput("mid_rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) sawDone++;
      @(negedge clk);
    end
    checkOutput("mid_rst_no_done", 32'(sawDone), 32'd0);

    applyStimulus(2'b10, 8'h10, 8'h20, 8'h00, bc, gd);
    checkOutput("post_rst_done", 32'(gd), 32'd1);
    checkOutput("post_rst_busycyc", 32'(bc), 32'd8);
    checkOutput("post_rst_result", 32'(result), 32'h30);
    checkOutput("post_rst_carry", 32'(carry_out), 32'd0);
    checkOutput("post_rst_zero", 32'(zero), 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
